// File: rtl/rat_pkg.sv
// Shared constants, CFG address decode and priority helper for the interrupt controller.
package rat_pkg;

    localparam int unsigned MAX_CH = 8;
    localparam int unsigned VEC_W  = 10;
    localparam int unsigned ID_W   = 3;

    typedef enum logic [1:0] {
        CfgEnable = 2'b00,
        CfgMode   = 2'b01,
        CfgClear  = 2'b10,
        CfgRsvd   = 2'b11
    } cfg_addr_e;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [ID_W-1:0] first_set(input logic [MAX_CH-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one raw line plus a rising-edge pulse from a third flop.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q, sync_q, prev_q;

    // Synchronizer chain and edge-history flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: per-channel edge/level pending, fixed lowest-index priority,
// single level of service (no nesting), global enable handled with SEI/CLI/RETI.
module intr_ctrl
    import rat_pkg::*;
#(
    parameter int unsigned       NUM_CH   = 8,
    parameter logic [VEC_W-1:0]  VEC_BASE = 10'h3F8,
    parameter logic [NUM_CH-1:0] MODE_RST = '1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] IRQ,
    input  logic              CFG_WE,
    input  logic [1:0]        CFG_ADDR,
    input  logic [7:0]        CFG_DIN,
    input  logic              GIE_SET,
    input  logic              GIE_CLR,
    input  logic              INT_ACK,
    input  logic              RETI,
    output logic              INT_REQ,
    output logic [VEC_W-1:0]  INT_VEC,
    output logic [ID_W-1:0]   INT_ID,
    output logic [MAX_CH-1:0] PEND,
    output logic              IN_SVC
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("intr_ctrl: NUM_CH must be in 1..8");
    end
    if (int'(VEC_BASE) + int'(NUM_CH) - 1 > (2 ** VEC_W) - 1) begin : g_bad_vec_base
        $error("intr_ctrl: vector table overflows the 10-bit address space");
    end

    logic [NUM_CH-1:0] irq_sync, irq_rise;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        sync_edge u_sync_edge (
            .clk_i  (CLK),
            .rst_ni (RESET),
            .d_i    (IRQ[i]),
            .sync_o (irq_sync[i]),
            .rise_o (irq_rise[i])
        );
    end

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] mode_q, mode_d;  // 1 = edge, 0 = level
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic              gie_q, gie_d;
    logic              in_svc_q, in_svc_d;
    logic              int_req_q, int_req_d;
    logic [ID_W-1:0]   id_q, id_d;

    cfg_addr_e         cfg_addr;
    logic [NUM_CH-1:0] cfg_din;
    logic              wr_en, wr_mode, wr_clr;
    logic              ack_acc;
    logic [NUM_CH-1:0] ack_clr, clr;
    logic [NUM_CH-1:0] active;
    logic [ID_W-1:0]   winner;

    assign cfg_addr = cfg_addr_e'(CFG_ADDR);
    assign cfg_din  = CFG_DIN[NUM_CH-1:0];
    assign wr_en    = CFG_WE && (cfg_addr == CfgEnable);
    assign wr_mode  = CFG_WE && (cfg_addr == CfgMode);
    assign wr_clr   = CFG_WE && (cfg_addr == CfgClear);

    // An acknowledge only counts while a request is actually being presented.
    assign ack_acc  = INT_ACK & int_req_q;
    assign ack_clr  = ack_acc ? (NUM_CH'(1) << id_q) : '0;
    assign clr      = ack_clr | (wr_clr ? cfg_din : '0);

    assign active   = pend_q & en_q;
    assign winner   = first_set(MAX_CH'(active));

    // Next-state for configuration, pending bits, global enable, service flag and request.
    always_comb begin
        en_d   = wr_en ? cfg_din : en_q;
        mode_d = wr_mode ? cfg_din : mode_q;
        pend_d = pend_q;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // Level channels track the line; a write switching a channel to level drops any
            // latched edge at the same time.
            if (!mode_q[i] || (wr_mode && !cfg_din[i])) begin
                pend_d[i] = irq_sync[i];
            end else begin
                // A fresh edge beats a simultaneous clear.
                pend_d[i] = irq_rise[i] | (pend_q[i] & ~clr[i]);
            end
        end

        if (GIE_CLR || ack_acc) begin
            gie_d = 1'b0;
        end else if (GIE_SET || RETI) begin
            gie_d = 1'b1;
        end else begin
            gie_d = gie_q;
        end

        if (ack_acc) begin
            in_svc_d = 1'b1;
        end else if (RETI) begin
            in_svc_d = 1'b0;
        end else begin
            in_svc_d = in_svc_q;
        end

        int_req_d = gie_d & ~in_svc_d & (|active);

        // While servicing, the vector stays on the channel that was acknowledged.
        if (in_svc_d) begin
            id_d = id_q;
        end else begin
            id_d = (|active) ? winner : '0;
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            en_q      <= '0;
            mode_q    <= MODE_RST;
            pend_q    <= '0;
            gie_q     <= 1'b0;
            in_svc_q  <= 1'b0;
            int_req_q <= 1'b0;
            id_q      <= '0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            gie_q     <= gie_d;
            in_svc_q  <= in_svc_d;
            int_req_q <= int_req_d;
            id_q      <= id_d;
        end
    end

    assign INT_REQ = int_req_q;
    assign INT_ID  = id_q;
    assign INT_VEC = VEC_BASE + VEC_W'(id_q);
    assign PEND    = MAX_CH'(pend_q);
    assign IN_SVC  = in_svc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: one-cycle stimulus table plus hand sequences for corner cases.
module tb_intr_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] IRQ = '0;
    logic       CFG_WE = 1'b0;
    logic [1:0] CFG_ADDR = '0;
    logic [7:0] CFG_DIN = '0;
    logic       GIE_SET = 1'b0, GIE_CLR = 1'b0, INT_ACK = 1'b0, RETI = 1'b0;
    logic       INT_REQ, IN_SVC;
    logic [9:0] INT_VEC;
    logic [2:0] INT_ID;
    logic [7:0] PEND;

    int checks = 0;
    int failures = 0;

    intr_ctrl #(
        .NUM_CH   (8),
        .VEC_BASE (10'h3F8),
        .MODE_RST (8'hFF)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IRQ      (IRQ),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_DIN  (CFG_DIN),
        .GIE_SET  (GIE_SET),
        .GIE_CLR  (GIE_CLR),
        .INT_ACK  (INT_ACK),
        .RETI     (RETI),
        .INT_REQ  (INT_REQ),
        .INT_VEC  (INT_VEC),
        .INT_ID   (INT_ID),
        .PEND     (PEND),
        .IN_SVC   (IN_SVC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [1:0] addr;
        logic [7:0] din;
        logic       gs, gc, ack, reti;
        logic       req;
        logic [2:0] id;
        logic [7:0] pend;
        logic       svc;
    } vec_t;

    localparam int NVEC = 42;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                                input logic [7:0] din, input logic gs, input logic gc,
                                input logic ack, input logic reti, input logic req,
                                input logic [2:0] id, input logic [7:0] pend, input logic svc);
        vec_t v;
        v.irq = irq; v.we = we; v.addr = addr; v.din = din;
        v.gs = gs; v.gc = gc; v.ack = ack; v.reti = reti;
        v.req = req; v.id = id; v.pend = pend; v.svc = svc;
        return v;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic req, input logic [2:0] id,
                       input logic [7:0] pend, input logic svc);
        cmp(nm, "INT_REQ", 10'(INT_REQ), 10'(req));
        cmp(nm, "INT_ID", 10'(INT_ID), 10'(id));
        cmp(nm, "INT_VEC", INT_VEC, 10'h3F8 + 10'(id));
        cmp(nm, "PEND", 10'(PEND), 10'(pend));
        cmp(nm, "IN_SVC", 10'(IN_SVC), 10'(svc));
    endtask

    // Hold one set of inputs across exactly one rising edge, then settle.
    task automatic drive(input logic [7:0] irq, input logic we, input logic [1:0] addr,
                         input logic [7:0] din, input logic gs, input logic gc,
                         input logic ack, input logic reti);
        IRQ = irq; CFG_WE = we; CFG_ADDR = addr; CFG_DIN = din;
        GIE_SET = gs; GIE_CLR = gc; INT_ACK = ack; RETI = reti;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        IRQ = '0; CFG_WE = 0; CFG_ADDR = '0; CFG_DIN = '0;
        GIE_SET = 0; GIE_CLR = 0; INT_ACK = 0; RETI = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", 0, 0, 8'h00, 0);
        RESET = 1'b1;
    endtask

    initial begin
        // irq, we, addr, din, gs, gc, ack, reti | req, id, pend, svc
        tbl[0]  = mk(8'h00, 1, 2'd0, 8'h04, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[2]  = mk(8'h04, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[3]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[4]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h04, 0);
        tbl[5]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h04, 0);
        tbl[6]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 1, 0, 0, 2, 8'h00, 1);
        tbl[7]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 2, 8'h00, 1);
        tbl[8]  = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[9]  = mk(8'h00, 1, 2'd0, 8'h22, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[10] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[11] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[12] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h22, 0);
        tbl[13] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h22, 0);
        tbl[14] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h20, 1);
        tbl[15] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h20, 1);
        tbl[16] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 1, 1, 5, 8'h20, 0);
        tbl[17] = mk(8'h22, 0, 2'd0, 8'h00, 0, 0, 1, 0, 0, 5, 8'h00, 1);
        tbl[18] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[19] = mk(8'h00, 1, 2'd0, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[20] = mk(8'h00, 0, 2'd0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[21] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[22] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[23] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tbl[24] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tbl[25] = mk(8'h01, 0, 2'd0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h01, 0);
        tbl[26] = mk(8'h01, 0, 2'd0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h01, 0);
        tbl[27] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h01, 0);
        tbl[28] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tbl[29] = mk(8'h00, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tbl[30] = mk(8'h00, 1, 2'd1, 8'hFE, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[31] = mk(8'h00, 1, 2'd0, 8'h01, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[32] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[33] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        tbl[34] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tbl[35] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h01, 0);
        tbl[36] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h01, 1);
        tbl[37] = mk(8'h01, 0, 2'd0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h01, 0);
        tbl[38] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h01, 0);
        tbl[39] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h01, 0);
        tbl[40] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        tbl[41] = mk(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].irq, tbl[i].we, tbl[i].addr, tbl[i].din,
                  tbl[i].gs, tbl[i].gc, tbl[i].ack, tbl[i].reti);
            chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].id, tbl[i].pend, tbl[i].svc);
        end

        // ACK on ch3 in the same cycle as a new ch3 edge: pending survives, re-request on RETI.
        do_reset();
        drive(8'h00, 1, 2'd0, 8'h08, 0, 0, 0, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("ack_edge_pend", 0, 0, 8'h08, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("ack_edge_req", 1, 3, 8'h08, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("ack_edge_hold", 1, 3, 8'h08, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 1, 0); chk("ack_edge_same", 0, 3, 8'h08, 1);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("ack_edge_svc", 0, 3, 8'h08, 1);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1); chk("ack_edge_reti", 1, 3, 8'h08, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 1, 0); chk("ack_edge_ack2", 0, 3, 8'h00, 1);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1); chk("ack_edge_done", 0, 0, 8'h00, 0);

        // Write-1-to-clear removes a latched edge.
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("w1c_pend", 0, 0, 8'h08, 0);
        drive(8'h00, 1, 2'd2, 8'h08, 0, 0, 0, 0); chk("w1c_clear", 1, 3, 8'h00, 0);
        drive(8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("w1c_after", 0, 0, 8'h00, 0);

        // Reset mid-service, then synchronizer refill with IRQ[3] held high.
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("svc_pend", 0, 0, 8'h08, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("svc_req", 1, 3, 8'h08, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 1, 0); chk("svc_in", 0, 3, 8'h00, 1);
        #2 RESET = 1'b0;
        #1 chk("mid_reset", 0, 0, 8'h00, 0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        drive(8'h08, 0, 2'd0, 8'h00, 1, 0, 0, 0); chk("refill1", 0, 0, 8'h00, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("refill2", 0, 0, 8'h00, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("refill3", 0, 0, 8'h08, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("en_cleared", 0, 0, 8'h08, 0);
        drive(8'h08, 1, 2'd0, 8'h08, 0, 0, 0, 0); chk("en_write", 0, 0, 8'h08, 0);
        drive(8'h08, 0, 2'd0, 8'h00, 0, 0, 0, 0); chk("en_req", 1, 3, 8'h08, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
